// File: rtl/pool3_blob_serializer.sv
// Buffers wide pool3 blob words in a small FIFO and emits them as narrow beats, LSB channels first.
// Also tracks the frame length so a malformed frame raises a sticky error while data flows unchanged.
module pool3_blob_serializer #(
    parameter int DIN_W       = 256,
    parameter int DOUT_W      = 32,
    parameter int FIFO_DEPTH  = 2,
    parameter int FRAME_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blob_din_en,
    output logic              blob_din_rdy,
    input  logic              blob_din_eop,
    input  logic [DIN_W-1:0]  blob_din,
    output logic              blob_dout_en,
    input  logic              blob_dout_rdy,
    output logic              blob_dout_eop,
    output logic [DOUT_W-1:0] blob_dout,
    output logic              err_len
);

    localparam int RATIO   = DIN_W / DOUT_W;
    localparam int BEAT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int ENTRY_W = DIN_W + 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state_q, state_d;
    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [BEAT_W-1:0]    beat_idx_q, beat_idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_len_q, err_len_d;
    logic                 alive_q;

    logic [ENTRY_W-1:0]   head_entry;
    logic                 push;
    logic                 pop;
    logic                 beat_ok;
    logic                 last_beat;
    logic                 send;
    logic [31:0]          cnt_next;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // alive_q keeps rdy low for the first cycle after reset releases
    assign blob_din_rdy = alive_q && (occ_q != OCC_W'(FIFO_DEPTH));
    assign head_entry   = mem_q[rd_ptr_q];
    assign send         = (state_q == SEND);
    assign last_beat    = (beat_idx_q == BEAT_W'(RATIO - 1));
    assign push         = blob_din_en && blob_din_rdy;
    assign beat_ok      = send && blob_dout_rdy;
    assign pop          = beat_ok && last_beat;

    always_comb begin
        blob_dout_en  = send;
        blob_dout_eop = send && head_entry[DIN_W] && last_beat;
        blob_dout     = '0;
        if (send) begin
            blob_dout = head_entry[beat_idx_q*DOUT_W +: DOUT_W];
        end
        err_len = err_len_q;
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        beat_idx_d = beat_idx_q;
        cnt_d      = cnt_q;
        err_len_d  = err_len_q;
        state_d    = state_q;
        cnt_next   = 32'(cnt_q) + 32'd1;

        if (push) begin
            mem_d[wr_ptr_q] = {blob_din_eop, blob_din};
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        if (beat_ok) begin
            beat_idx_d = last_beat ? '0 : beat_idx_q + 1'b1;
        end

        // An eop word closes the frame; a non-eop word that reaches the length wraps the count
        if (push && (FRAME_WORDS > 0)) begin
            if (blob_din_eop) begin
                if (cnt_next != FRAME_WORDS) begin
                    err_len_d = 1'b1;
                end
                cnt_d = '0;
            end else if (cnt_next == FRAME_WORDS) begin
                err_len_d = 1'b1;
                cnt_d     = '0;
            end else begin
                cnt_d = CNT_W'(cnt_next);
            end
        end

        case (state_q)
            IDLE: if (occ_d != '0) state_d = SEND;
            SEND: if (occ_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            beat_idx_q <= '0;
            cnt_q      <= '0;
            err_len_q  <= 1'b0;
            alive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            beat_idx_q <= beat_idx_d;
            cnt_q      <= cnt_d;
            err_len_q  <= err_len_d;
            alive_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
